// File: rtl/regfile_writeback_arbiter.sv
// Write-back arbiter for the 32x32 register bank: per-source in-order FIFOs for ALU and LSU
// results, round-robin retired onto the bank's single registered write port.

module regfile_wb_fifo #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  push,
  input  logic [ADDR_WIDTH-1:0] push_addr,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop,
  output logic                  ready,
  output logic                  not_empty,
  output logic [ADDR_WIDTH-1:0] head_addr,
  output logic [DATA_WIDTH-1:0] head_data
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [ADDR_WIDTH-1:0] addr_mem [DEPTH];
  logic [DATA_WIDTH-1:0] data_mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;

  // NOTE: storage is deliberately not reset; count alone defines which entries are live.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr] <= push_addr;
      data_mem[wr_ptr] <= push_data;
    end
  end

  // NOTE: sequential state uses <= so every register sees the pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Ready depends only on registered occupancy, never on a same-cycle pop.
  assign ready     = (count < CW'(DEPTH));
  assign not_empty = (count != '0);
  assign head_addr = addr_mem[rd_ptr];
  assign head_data = data_mem[rd_ptr];
endmodule

module regfile_writeback_arbiter #(
  parameter int DEPTH      = 2,
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [ADDR_WIDTH-1:0] alu_addr,
  input  logic [DATA_WIDTH-1:0] alu_data,
  input  logic                  lsu_valid,
  output logic                  lsu_ready,
  input  logic [ADDR_WIDTH-1:0] lsu_addr,
  input  logic [DATA_WIDTH-1:0] lsu_data,
  output logic                  write_enable,
  output logic [ADDR_WIDTH-1:0] write_address,
  output logic [DATA_WIDTH-1:0] write_data,
  output logic                  pending
);
  typedef enum logic {SRC_ALU = 1'b0, SRC_LSU = 1'b1} src_e;

  src_e                  rr_ptr, rr_next;
  logic                  alu_push, lsu_push;
  logic                  grant_alu, grant_lsu;
  logic                  alu_ne, lsu_ne;
  logic [ADDR_WIDTH-1:0] alu_head_addr, lsu_head_addr;
  logic [DATA_WIDTH-1:0] alu_head_data, lsu_head_data;

  // x0 writes complete the handshake but are never enqueued.
  assign alu_push = alu_valid && alu_ready && (alu_addr != '0);
  assign lsu_push = lsu_valid && lsu_ready && (lsu_addr != '0);

  regfile_wb_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_alu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (alu_push),
    .push_addr (alu_addr),
    .push_data (alu_data),
    .pop       (grant_alu),
    .ready     (alu_ready),
    .not_empty (alu_ne),
    .head_addr (alu_head_addr),
    .head_data (alu_head_data)
  );

  regfile_wb_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_lsu_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (lsu_push),
    .push_addr (lsu_addr),
    .push_data (lsu_data),
    .pop       (grant_lsu),
    .ready     (lsu_ready),
    .not_empty (lsu_ne),
    .head_addr (lsu_head_addr),
    .head_data (lsu_head_data)
  );

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    grant_alu = 1'b0;
    grant_lsu = 1'b0;
    rr_next   = rr_ptr;
    if (alu_ne && lsu_ne) begin
      grant_alu = (rr_ptr == SRC_ALU);
      grant_lsu = (rr_ptr == SRC_LSU);
      rr_next   = (rr_ptr == SRC_ALU) ? SRC_LSU : SRC_ALU;
    end else if (alu_ne) begin
      grant_alu = 1'b1;
    end else if (lsu_ne) begin
      grant_lsu = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr        <= SRC_ALU;
      write_enable  <= 1'b0;
      write_address <= '0;
      write_data    <= '0;
    end else begin
      rr_ptr       <= rr_next;
      write_enable <= grant_alu || grant_lsu;
      if (grant_alu) begin
        write_address <= alu_head_addr;
        write_data    <= alu_head_data;
      end else if (grant_lsu) begin
        write_address <= lsu_head_addr;
        write_data    <= lsu_head_data;
      end
    end
  end

  assign pending = alu_ne || lsu_ne || write_enable;
endmodule

// File: tb/tb_regfile_writeback_arbiter.sv
// Directed bench for regfile_writeback_arbiter: reset, single write, x0 drop, contention,
// backpressure and mid-stream reset, with a small register-bank model on the write port.

module tb_regfile_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0;
  logic        alu_ready, lsu_ready;
  logic [4:0]  alu_addr = '0, lsu_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        write_enable, pending;
  logic [4:0]  write_address;
  logic [31:0] write_data;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] bank [32];
  logic [4:0]  wq_addr [$];
  logic [31:0] wq_data [$];
  int          wq_cyc  [$];

  always #5 clk = ~clk;

  regfile_writeback_arbiter #(.DEPTH(2), .DATA_WIDTH(32), .ADDR_WIDTH(5)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_addr      (alu_addr),
    .alu_data      (alu_data),
    .lsu_valid     (lsu_valid),
    .lsu_ready     (lsu_ready),
    .lsu_addr      (lsu_addr),
    .lsu_data      (lsu_data),
    .write_enable  (write_enable),
    .write_address (write_address),
    .write_data    (write_data),
    .pending       (pending)
  );

  always @(posedge clk) if (write_enable === 1'b1) bank[write_address] <= write_data;

  always @(negedge clk) begin
    cyc++;
    if (write_enable === 1'b1) begin
      wq_addr.push_back(write_address);
      wq_data.push_back(write_data);
      wq_cyc.push_back(cyc);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    wq_addr.delete();
    wq_data.delete();
    wq_cyc.delete();
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0;
    alu_valid = 1'b0;
    lsu_valid = 1'b0;
    repeat (n) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Present one entry per negedge; it is consumed at the next posedge whenever ready is high.
  task automatic drive_alu(input logic [4:0] a[$], input logic [31:0] d[$]);
    int idx = 0;
    int guard = 0;
    while (idx < a.size() && guard < 50) begin
      @(negedge clk);
      alu_valid = 1'b1;
      alu_addr  = a[idx];
      alu_data  = d[idx];
      if (alu_ready) idx++;
      guard++;
    end
    if (idx < a.size()) check("alu_drive_timeout", 64'(idx), 64'(a.size()));
    @(negedge clk);
    alu_valid = 1'b0;
  endtask

  task automatic drive_lsu(input logic [4:0] a[$], input logic [31:0] d[$]);
    int idx = 0;
    int guard = 0;
    while (idx < a.size() && guard < 50) begin
      @(negedge clk);
      lsu_valid = 1'b1;
      lsu_addr  = a[idx];
      lsu_data  = d[idx];
      if (lsu_ready) idx++;
      guard++;
    end
    if (idx < a.size()) check("lsu_drive_timeout", 64'(idx), 64'(a.size()));
    @(negedge clk);
    lsu_valid = 1'b0;
  endtask

  task automatic check_log(input string tag, input logic [4:0] exp_a[$]);
    check({tag, "_count"}, 64'(wq_addr.size()), 64'(exp_a.size()));
    for (int i = 0; i < exp_a.size() && i < wq_addr.size(); i++) begin
      check($sformatf("%s_addr%0d", tag, i), 64'(wq_addr[i]), 64'(exp_a[i]));
      check($sformatf("%s_data%0d", tag, i), 64'(wq_data[i]), 64'(32'hA000_0000 | 32'(exp_a[i])));
      check($sformatf("%s_gap%0d", tag, i), 64'(wq_cyc[i] - wq_cyc[0]), 64'(i));
    end
  endtask

  logic [4:0]  qa_a[$], qb_a[$], exp_a[$];
  logic [31:0] qa_d[$], qb_d[$];

  initial begin
    // 1: reset held for three cycles with valids high
    alu_valid = 1'b1; alu_addr = 5'd3; alu_data = 32'h1111;
    lsu_valid = 1'b1; lsu_addr = 5'd4; lsu_data = 32'h2222;
    repeat (3) @(negedge clk);
    check("rst_we_during", 64'(write_enable), 64'd0);
    alu_valid = 1'b0; lsu_valid = 1'b0; rst_n = 1'b1;
    @(negedge clk); #1;
    check("rst_we", 64'(write_enable), 64'd0);
    check("rst_alu_ready", 64'(alu_ready), 64'd1);
    check("rst_lsu_ready", 64'(lsu_ready), 64'd1);
    check("rst_pending", 64'(pending), 64'd0);
    check("rst_addr", 64'(write_address), 64'd0);
    check("rst_data", 64'(write_data), 64'd0);

    // 2: single ALU write, two-edge latency, one-cycle pulse
    clear_log();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd5; alu_data = 32'hDEAD_BEEF;
    @(negedge clk); #1;
    alu_valid = 1'b0;
    check("single_we_n", 64'(write_enable), 64'd0);
    check("single_pending_n", 64'(pending), 64'd1);
    @(negedge clk); #1;
    check("single_we_n1", 64'(write_enable), 64'd1);
    check("single_addr", 64'(write_address), 64'd5);
    check("single_data", 64'(write_data), 64'hDEAD_BEEF);
    @(negedge clk); #1;
    check("single_we_n2", 64'(write_enable), 64'd0);
    check("single_bank5", 64'(bank[5]), 64'hDEAD_BEEF);
    check("single_addr_hold", 64'(write_address), 64'd5);
    check("single_pending_done", 64'(pending), 64'd0);

    // 3: write to x0 is accepted and dropped
    clear_log();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd0; alu_data = 32'h1234;
    check("x0_ready", 64'(alu_ready), 64'd1);
    @(negedge clk);
    alu_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("x0_pending%0d", i), 64'(pending), 64'd0);
      @(negedge clk);
    end
    #1;
    check("x0_no_write", 64'(wq_addr.size()), 64'd0);
    check("x0_addr_hold", 64'(write_address), 64'd5);

    // 4: contention, four entries per source pushed back-to-back
    clear_log();
    qa_a = '{5'd1, 5'd2, 5'd3, 5'd4};
    qb_a = '{5'd11, 5'd12, 5'd13, 5'd14};
    qa_d.delete(); qb_d.delete();
    foreach (qa_a[i]) qa_d.push_back(32'hA000_0000 | 32'(qa_a[i]));
    foreach (qb_a[i]) qb_d.push_back(32'hA000_0000 | 32'(qb_a[i]));
    fork
      drive_alu(qa_a, qa_d);
      drive_lsu(qb_a, qb_d);
    join
    repeat (8) @(negedge clk);
    #1;
    exp_a = '{5'd1, 5'd11, 5'd2, 5'd12, 5'd3, 5'd13, 5'd4, 5'd14};
    check_log("rr", exp_a);
    check("rr_pending_done", 64'(pending), 64'd0);

    // 5: backpressure on LSU from a clean round-robin state
    do_reset(2);
    clear_log();
    qa_a = '{5'd21, 5'd22, 5'd23};
    qb_a = '{5'd24, 5'd25, 5'd26};
    qa_d.delete(); qb_d.delete();
    foreach (qa_a[i]) qa_d.push_back(32'hA000_0000 | 32'(qa_a[i]));
    foreach (qb_a[i]) qb_d.push_back(32'hA000_0000 | 32'(qb_a[i]));
    fork
      drive_alu(qa_a, qa_d);
      drive_lsu(qb_a, qb_d);
      begin
        repeat (3) @(negedge clk);
        #1;
        check("bp_lsu_ready_full", 64'(lsu_ready), 64'd0);
        check("bp_alu_ready", 64'(alu_ready), 64'd1);
      end
    join
    repeat (8) @(negedge clk);
    #1;
    exp_a = '{5'd21, 5'd24, 5'd22, 5'd25, 5'd23, 5'd26};
    check_log("bp", exp_a);

    // 6: reset with two entries queued discards them
    clear_log();
    @(negedge clk);
    alu_valid = 1'b1; alu_addr = 5'd7; alu_data = 32'h7777;
    lsu_valid = 1'b1; lsu_addr = 5'd8; lsu_data = 32'h8888;
    @(negedge clk);
    alu_valid = 1'b0; lsu_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk); #1;
    check("midrst_we", 64'(write_enable), 64'd0);
    check("midrst_pending", 64'(pending), 64'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("midrst_no_write", 64'(wq_addr.size()), 64'd0);
    check("midrst_pending_after", 64'(pending), 64'd0);
    check("midrst_alu_ready", 64'(alu_ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
